// File: rtl/sipo_stream.sv
// Serial-in/parallel-out packer: gathers N/M words of M bits into one N-bit block,
// double buffered so a full block can drain while the next one is assembled.
module sipo_stream #(
  parameter int N            = 1344,
  parameter int M            = 64,
  parameter int FIRST_AT_MSB = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [M-1:0]                  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N-1:0]                  out_data,
  output logic [$clog2(N/M+1)-1:0]      out_words
);

  localparam int WORDS = N / M;
  localparam int CW    = $clog2(WORDS);
  localparam int OW    = $clog2(WORDS + 1);

  if ((N % M) != 0 || (N / M) < 2) begin : g_bad_params
    $error("sipo_stream: N must be a multiple of M with at least two words per block");
  end

  logic [CW-1:0] cnt_r;
  logic [N-1:0]  buf_r;
  logic          flush_pend_r;
  logic          out_valid_r;
  logic [N-1:0]  out_data_r;
  logic [OW-1:0] out_words_r;

  logic          busy_s;
  logic          last_slot_s;
  logic          flush_req_s;
  logic          ready_s;
  logic          accept_s;
  logic [OW-1:0] fill_s;
  logic          complete_s;
  logic          pend_nxt_s;
  int            slot_s;
  logic [N-1:0]  buf_s;

  // Handshake, fill and completion decode; a flush stalls input like a completing word.
  always_comb begin
    busy_s      = out_valid_r & ~out_ready;
    last_slot_s = (cnt_r == CW'(WORDS - 1));
    flush_req_s = flush | flush_pend_r;
    ready_s     = ~(busy_s & (last_slot_s | flush_req_s)) & ~clear;
    accept_s    = in_valid & ready_s;
    fill_s      = OW'(cnt_r) + OW'(accept_s);
    complete_s  = ~clear & ~busy_s &
                  ((accept_s & last_slot_s) | (flush_req_s & (fill_s != OW'(0))));
    pend_nxt_s  = ~clear & ~complete_s & flush_req_s & (fill_s != OW'(0));
  end

  // Merge the accepted word into its slot of the assembly buffer.
  always_comb begin
    buf_s  = buf_r;
    slot_s = (FIRST_AT_MSB != 0) ? (WORDS - 1 - int'(cnt_r)) : int'(cnt_r);
    if (accept_s) begin
      buf_s[slot_s*M +: M] = in_data;
    end else begin
      buf_s = buf_r;
    end
  end

  // Assembly state and output register; clear overrides every concurrent event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= CW'(0);
      buf_r        <= '0;
      flush_pend_r <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_words_r  <= OW'(0);
    end else if (clear) begin
      cnt_r        <= CW'(0);
      buf_r        <= '0;
      flush_pend_r <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_words_r  <= OW'(0);
    end else if (complete_s) begin
      cnt_r        <= CW'(0);
      buf_r        <= '0;
      flush_pend_r <= 1'b0;
      out_valid_r  <= 1'b1;
      out_data_r   <= buf_s;
      out_words_r  <= fill_s;
    end else begin
      cnt_r        <= CW'(fill_s);
      buf_r        <= buf_s;
      flush_pend_r <= pend_nxt_s;
      out_valid_r  <= out_valid_r & ~out_ready;
      out_data_r   <= out_data_r;
      out_words_r  <= out_words_r;
    end
  end

  assign in_ready  = ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_words = out_words_r;

endmodule

// File: tb/tb_sipo_stream.sv
// Directed bench for sipo_stream with N=256, M=64; a second instance checks MSB-first order.
module tb_sipo_stream;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         flush;
  logic         in_valid;
  logic [63:0]  in_data;
  logic         out_ready;
  logic         in_ready;
  logic         out_valid;
  logic [255:0] out_data;
  logic [2:0]   out_words;
  logic         in_ready_m;
  logic         out_valid_m;
  logic [255:0] out_data_m;
  logic [2:0]   out_words_m;

  int checks   = 0;
  int failures = 0;

  sipo_stream #(.N(256), .M(64), .FIRST_AT_MSB(0)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_words(out_words)
  );

  sipo_stream #(.N(256), .M(64), .FIRST_AT_MSB(1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .clear(clear), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
    .out_words(out_words_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  initial begin
    rst_n = 1'b0; clear = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = 64'h0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_data", out_data, 256'h0);
    chk("rst_out_words", 256'(out_words), 256'(0));
    rst_n = 1'b1;
    tick();

    // basic block, both word orders
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = rep(8'(8'h11 * (i + 1)));
      tick();
      if (i == 2) chk("basic_latency", 256'(out_valid), 256'(0));
    end
    in_valid = 1'b0;
    #1;
    chk("basic_valid", 256'(out_valid), 256'(1));
    chk("basic_data", out_data, {rep(8'h44), rep(8'h33), rep(8'h22), rep(8'h11)});
    chk("basic_words", 256'(out_words), 256'(4));
    chk("msb_data", out_data_m, {rep(8'h11), rep(8'h22), rep(8'h33), rep(8'h44)});
    tick();
    chk("basic_drained", 256'(out_valid), 256'(0));

    // 12 back-to-back words, no stalls, block every 4 cycles
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_data = 64'(i + 1);
      #1;
      chk("stream_ready", 256'(in_ready), 256'(1));
      tick();
      chk("stream_valid", 256'(out_valid), 256'((i % 4) == 3));
    end
    in_valid = 1'b0;
    chk("stream_last_data", out_data, {64'd12, 64'd11, 64'd10, 64'd9});
    tick();
    chk("stream_idle", 256'(out_valid), 256'(0));

    // backpressure: output held, 4th word stalls until out_ready rises
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = rep(8'(8'hA1 + i));
      #1;
      chk("bp_ready", 256'(in_ready), 256'(1));
      tick();
    end
    in_data = rep(8'hA8);
    #1;
    chk("bp_stall", 256'(in_ready), 256'(0));
    tick();
    chk("bp_hold_valid", 256'(out_valid), 256'(1));
    chk("bp_hold_data", out_data, {rep(8'hA4), rep(8'hA3), rep(8'hA2), rep(8'hA1)});
    chk("bp_still_stall", 256'(in_ready), 256'(0));
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 256'(in_ready), 256'(1));
    tick();
    in_valid = 1'b0;
    #1;
    chk("bp_second_valid", 256'(out_valid), 256'(1));
    chk("bp_second_data", out_data, {rep(8'hA8), rep(8'hA7), rep(8'hA6), rep(8'hA5)});
    tick();
    chk("bp_idle", 256'(out_valid), 256'(0));

    // flush of a 2-word partial block, then flush when empty
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = rep(8'(8'hC1 + i));
      tick();
    end
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", 256'(out_valid), 256'(1));
    chk("flush_words", 256'(out_words), 256'(2));
    chk("flush_data", out_data, {128'h0, rep(8'hC2), rep(8'hC1)});
    chk("flush_msb_data", out_data_m, {rep(8'hC1), rep(8'hC2), 128'h0});
    tick();
    chk("flush_drained", 256'(out_valid), 256'(0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_empty", 256'(out_valid), 256'(0));
    tick();
    chk("flush_empty_later", 256'(out_valid), 256'(0));

    // clear at cnt==3 with a word offered; only the new block appears
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = rep(8'(8'hD1 + i));
      tick();
    end
    clear = 1'b1; in_data = rep(8'hDD);
    #1;
    chk("clear_ready", 256'(in_ready), 256'(0));
    tick();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = rep(8'(8'hE1 + i));
      tick();
      if (i == 2) chk("clear_no_early", 256'(out_valid), 256'(0));
    end
    in_valid = 1'b0;
    chk("clear_valid", 256'(out_valid), 256'(1));
    chk("clear_data", out_data, {rep(8'hE4), rep(8'hE3), rep(8'hE2), rep(8'hE1)});
    tick();

    // async reset with a held block and a partial block
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = rep(8'(8'hF1 + i));
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", 256'(out_valid), 256'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_pulse_valid", 256'(out_valid), 256'(0));
    chk("rst_pulse_data", out_data, 256'h0);
    chk("rst_pulse_words", 256'(out_words), 256'(0));
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = rep(8'(8'h51 + i));
      tick();
    end
    in_valid = 1'b0;
    chk("post_rst_valid", 256'(out_valid), 256'(1));
    chk("post_rst_data", out_data, {rep(8'h54), rep(8'h53), rep(8'h52), rep(8'h51)});
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
